twiddle_gen: RTL
================

# twiddle_gen

Parametrised, runtime-generated twiddle-factor store for the NTT datapath: given modulus Q and primitive 2N-th root PSI (and its inverse PSI_INV), it computes psi^k or psi^-k for k = 0..N-1 by repeated modular multiplication. It writes them into an internal N-entry memory in bit-reversed or natural order, then serves registered random reads to the butterfly unit. It supersedes fixed per-(N, Q) constant tables: one instance covers any power-of-two N and either transform direction, selected per run.

## Interface
- WIDTH, 17: coefficient/twiddle word width; Q < 2^WIDTH
- LOG_N, 3: log2 of table depth N = 2^LOG_N
- Q, 65537: modulus
- PSI, 4: forward primitive 2N-th root of unity mod Q
- PSI_INV, 49153: PSI^-1 mod Q
- BITREV, 1: 1 = entry for power k stored at bitrev_LOG_N(k); 0 = stored at k
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin generation; sampled only in IDLE or READY
- inverse  in  1  0 = powers of PSI, 1 = powers of PSI_INV; latched with start
- busy  out  1  generation in progress
- ready  out  1  table valid, reads served
- done  out  1  one-cycle pulse when generation completes
- rd_en  in  1  read request
- rd_addr  in  LOG_N  read index
- rd_data  out  WIDTH  table word
- rd_valid  out  1  rd_data valid this cycle

## Operation
- FSM states: IDLE, GEN, READY.
- IDLE: wait for start. start=1 -> GEN. Latch inverse into mode_q. Set k=0, p=1.
- GEN: each cycle, write p to mem[BITREV ? bitrev(k) : k]. Update p <= (p * root) mod Q, where root = mode_q ? PSI_INV : PSI. Increment k.
  - After the write with k = N-1 -> READY. done=1 for that one cycle.
- READY: table is valid. start=1 -> GEN with a newly latched inverse. ready drops on the same edge. Old contents are not guaranteed during regeneration.
- start in GEN is ignored. inverse is ignored unless start is sampled.
- Arithmetic: full 2*WIDTH-bit product, reduced mod Q. Result is always in [0, Q-1]. p and every stored word are < Q.
- Reads: if rd_en && ready, then next cycle rd_valid=1 and rd_data=mem[rd_addr]. Otherwise rd_valid=0 next cycle and rd_data holds its last value.
- A read issued on the cycle READY->GEN is taken: it was sampled while ready=1.
- Reset: state=IDLE, k=0, p=1, mode_q=0, busy=0, ready=0, done=0, rd_valid=0, rd_data=0. Memory contents are not reset; they are invalid until the next completed GEN.
- rst during GEN aborts it. No done is issued; ready=0 until a full regeneration completes.
- rst has priority over start and rd_en in the same cycle.

## Timing
- start sampled at edge E0. GEN writes on edges E1..EN.
- busy=1 after E1..EN-1. done=1, ready=1, busy=0 after EN. Generation latency is N+1 edges from start to ready.
- Modular multiply is single-cycle: combinational product and reduction, registered into p. This gives one table entry per cycle.
- Read latency: 1 cycle. Full throughput: one read per cycle while ready.
- done coincides with the first cycle of ready=1. A read may be issued in that cycle.

## Structure
- Shared package ntt_pkg: WIDTH, Q defaults, and a bitrev function parametrised by LOG_N. The butterfly and address generators use the same package.
- One sub-module: mod_mul (WIDTH, Q), combinational a*b mod Q. It is kept separate so a Barrett/Montgomery version can replace it later without FSM changes.
- Memory: N x WIDTH register array with one write port (generator) and one registered read port.

## Test plan
- Forward, defaults (Q=65537, LOG_N=3, BITREV=1, inverse=0): start, wait for done, read 0..7 -> 1, 256, 16, 4096, 4, 1024, 64, 16384. ready arrives exactly 9 edges after start.
- Inverse, defaults: start with inverse=1, read 0..7 -> 1, 65281, 61441, 65521, 49153, 65473, 64513, 65533.
- BITREV=0, forward: read 0..7 -> 1, 4, 16, 64, 256, 1024, 4096, 16384.
- Handshake:
  - rd_en before any generation -> rd_valid stays 0.
  - start pulsed mid-GEN -> ignored; done occurs exactly once.
  - start in READY with toggled inverse -> ready drops next cycle, then the inverse table appears.
- Reset mid-GEN at k=4: assert rst one cycle -> all outputs zero, no done. A fresh start yields the correct full table.
- Back-to-back reads of addresses 7, 0, 3 on consecutive cycles -> rd_valid high three cycles, with data 16384, 1, 4096 (forward, defaults), each one cycle after its address.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT definitions: default word sizes, generator
// states and the bit-reversal helper used by the address units.
package ntt_pkg;

  localparam int WIDTH_DEF = 17;
  localparam int Q_DEF     = 65537;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    READY
  } gen_state_t;

  function automatic int bitrev(
    input int k,
    input int log_n
  );
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < log_n) begin
        r = (r << 1) | ((k >> i) & 1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Combinational a*b mod Q on a full double-width product.
// Drop-in point for a Barrett/Montgomery reducer later.
module mod_mul
  import ntt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int Q     = Q_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam logic [2*WIDTH-1:0] QW =
    (2*WIDTH)'(Q);

  logic [2*WIDTH-1:0] aw;
  logic [2*WIDTH-1:0] bw;
  logic [2*WIDTH-1:0] prod;

  assign aw   = {{WIDTH{1'b0}}, a};
  assign bw   = {{WIDTH{1'b0}}, b};
  assign prod = aw * bw;
  assign y    = WIDTH'(prod % QW);

endmodule

// File: rtl/twiddle_gen.sv
// Runtime twiddle table: fills N powers of psi (or psi^-1)
// into a local memory, then serves 1-cycle registered reads.
module twiddle_gen
  import ntt_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LOG_N   = 3,
  parameter int Q       = Q_DEF,
  parameter int PSI     = 4,
  parameter int PSI_INV = 49153,
  parameter int BITREV  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inverse,
  output logic             busy,
  output logic             ready,
  output logic             done,
  input  logic             rd_en,
  input  logic [LOG_N-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] K_LAST =
    LOG_N'(N - 1);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);
  localparam logic [WIDTH-1:0] R_FWD =
    WIDTH'(PSI);
  localparam logic [WIDTH-1:0] R_INV =
    WIDTH'(PSI_INV);

  gen_state_t state;
  gen_state_t state_d;

  logic [LOG_N-1:0] k;
  logic [LOG_N-1:0] waddr;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] root;
  logic             mode_q;
  logic             we;
  logic             init;
  logic             done_d;

  logic [WIDTH-1:0] mem [N];

  assign root = mode_q ? R_INV : R_FWD;

  assign waddr = (BITREV != 0)
    ? LOG_N'(bitrev(int'(k), LOG_N))
    : k;

  mod_mul #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_mul (
    .a (p),
    .b (root),
    .y (p_next)
  );

  always_comb begin
    state_d = state;
    we      = 1'b0;
    init    = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = GEN;
          init    = 1'b1;
        end
      end
      GEN: begin
        we = 1'b1;
        if (k == K_LAST) begin
          state_d = READY;
          done_d  = 1'b1;
        end
      end
      READY: begin
        if (start) begin
          state_d = GEN;
          init    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      p        <= ONE;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state <= state_d;
      busy  <= (state_d == GEN);
      ready <= (state_d == READY);
      done  <= done_d;
      if (init) begin
        k      <= '0;
        p      <= ONE;
        mode_q <= inverse;
      end else if (we) begin
        k <= k + 1'b1;
        p <= p_next;
      end
      // ready is still high on the READY->GEN edge
      rd_valid <= rd_en && ready;
      if (rd_en && ready) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= p;
    end
  end

endmodule
